// File: rtl/com_pkg.sv
// Shared constants for the Ethernet command receive stage and its parser.
package com_pkg;

    // Buffer layout and packet format
    localparam logic [7:0]  RAM_ADDR_INIT = 8'h0A;
    localparam logic [7:0]  PKT_LEN       = 8'h12;
    localparam logic [15:0] STD_HEAD      = 16'h55AA;
    localparam int          DATA_LATENCY  = 2;

    // One-hot receive states
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_LOAD = 5'b00010;
    localparam logic [4:0] ST_DROP = 5'b00100;
    localparam logic [4:0] ST_SEND = 5'b01000;
    localparam logic [4:0] ST_HOLD = 5'b10000;

    // Byte index increment that sticks at 8'hFF on oversized frames
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/com_ram.sv
// 256x8 simple dual-port buffer: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old byte.
module com_ram (
    input  logic       clk,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [7:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    logic [7:0] r_mem [0:255];
    logic [7:0] r_rd_data;

    // Write port and read-first registered read port
    // NOTE: the array and its read register have no reset; a reset would stop
    // the buffer from mapping onto a RAM block, and its contents are don't-care.
    // NOTE: non-blocking assignments make the read sample the pre-write byte.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/com_recv.sv
// Receive stage: loads one checked command packet into the local buffer and
// hands it to the parser over the fs_eth/fd_eth handshake.
module com_recv (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        rx_err,
    output logic        fs_eth,
    input  logic        fd_eth,
    input  logic [7:0]  rxa,
    output logic [7:0]  rxd,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    import com_pkg::*;

    logic [4:0]  r_state;
    logic [4:0]  w_state_next;
    logic [7:0]  r_idx;
    logic        r_hok;
    logic        r_in_frame;
    logic        r_skip;
    logic        r_fs_eth;
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_drop_cnt;
    logic [7:0]  r_rxd;

    logic        w_rx_end;
    logic        w_load;
    logic        w_take;
    logic        w_wr_en;
    logic [7:0]  w_wr_addr;
    logic        w_hok_now;
    logic        w_accept;
    logic        w_discard;
    logic        w_in_frame_next;
    logic        w_enter_load;
    logic        w_drop_inc;
    logic        w_pkt_inc;
    logic [7:0]  w_ram_q;

    assign w_rx_end        = rx_valid & rx_last;
    assign w_load          = (r_state == ST_LOAD);
    // A byte is taken into the packet only in LOAD while not skipping a stale frame
    assign w_take          = w_load & rx_valid & ~r_skip;
    assign w_wr_en         = w_take & (r_idx < PKT_LEN);
    assign w_wr_addr       = RAM_ADDR_INIT + r_idx;
    assign w_accept        = (r_idx == PKT_LEN - 8'd1) & w_hok_now & ~rx_err;
    // Frame ends that are not evaluated as a packet count as discards
    assign w_discard       = w_rx_end & (~w_load | r_skip);
    assign w_in_frame_next = rx_valid ? ~rx_last : r_in_frame;
    assign w_enter_load    = (w_state_next == ST_LOAD) & ~w_load;
    assign w_drop_inc      = (r_state == ST_DROP);
    assign w_pkt_inc       = (r_state == ST_HOLD) & ~fd_eth;

    // Header flag including the byte currently on rx_data
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (no latch).
        w_hok_now = r_hok;
        if (r_idx == 8'd0) begin
            w_hok_now = (rx_data == STD_HEAD[15:8]);
        end else if ((r_idx == 8'd1) && (rx_data != STD_HEAD[7:0])) begin
            w_hok_now = 1'b0;
        end
    end

    // Next-state logic of the receive FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_LOAD;
            ST_LOAD: if (w_take && rx_last) w_state_next = w_accept ? ST_SEND : ST_DROP;
            ST_DROP: w_state_next = ST_LOAD;
            ST_SEND: if (fd_eth) w_state_next = ST_HOLD;
            ST_HOLD: if (!fd_eth) w_state_next = ST_LOAD;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and registered packet-ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_fs_eth <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_fs_eth <= (w_state_next == ST_SEND);
        end
    end

    // Frame activity tracking; a frame already running when LOAD opens is skipped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_frame <= 1'b0;
            r_skip     <= 1'b0;
        end else begin
            r_in_frame <= w_in_frame_next;
            if (w_enter_load) begin
                r_skip <= w_in_frame_next;
            end else if (w_load && r_skip && w_rx_end) begin
                r_skip <= 1'b0;
            end
        end
    end

    // Byte index and header flag of the frame being loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= 8'd0;
            r_hok <= 1'b0;
        end else if (w_take) begin
            if (rx_last) begin
                r_idx <= 8'd0;
                r_hok <= 1'b0;
            end else begin
                r_idx <= sat_inc(r_idx);
                r_hok <= w_hok_now;
            end
        end
    end

    // Accepted and dropped frame counters; both wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_pkt_inc) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            r_drop_cnt <= r_drop_cnt + {15'd0, w_drop_inc} + {15'd0, w_discard};
        end
    end

    // Second read pipeline stage: output register after the RAM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd <= 8'h00;
        end else begin
            r_rxd <= w_ram_q;
        end
    end

    com_ram u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (rx_data),
        .i_rd_addr (rxa),
        .o_rd_data (w_ram_q)
    );

    assign fs_eth   = r_fs_eth;
    assign rxd      = r_rxd;
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_com_recv.sv
// Directed bench for com_recv: packet load, hand-off, rejects, skips, reset, wrap.
`timescale 1ns/1ps
module tb_com_recv;

    localparam logic [7:0] BASE = 8'h0A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        fs_eth;
    logic        fd_eth = 1'b0;
    logic [7:0]  rxa = 8'h00;
    logic [7:0]  rxd;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] frm  [0:18];
    logic [7:0] gold [0:18];

    com_recv dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_last  (rx_last),
        .rx_err   (rx_err),
        .fs_eth   (fs_eth),
        .fd_eth   (fd_eth),
        .rxa      (rxa),
        .rxd      (rxd),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_idle();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Valid packet 55 AA 00 01 00 1E followed by seed+i
    task automatic fill(input logic [7:0] seed);
        for (int i = 0; i < 19; i++) frm[i] = seed + 8'(i);
        frm[0] = 8'h55; frm[1] = 8'hAA; frm[2] = 8'h00;
        frm[3] = 8'h01; frm[4] = 8'h00; frm[5] = 8'h1E;
    endtask

    task automatic keep_gold();
        for (int i = 0; i < 19; i++) gold[i] = frm[i];
    endtask

    task automatic send_bytes(input int first, input int len, input logic err);
        for (int i = first; i < len; i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = (i == len - 1);
            rx_err   = err && (i == len - 1);
            tick();
        end
        rx_idle();
    endtask

    // Pipelined readback of the whole packet, one address per cycle
    task automatic read_all(input string tag);
        for (int i = 0; i < 19; i++) begin
            rxa = (i < 18) ? BASE + 8'(i) : BASE;
            tick();
            if (i >= 1) check(tag, {8'h00, rxd}, {8'h00, gold[i-1]});
        end
    endtask

    task automatic read1(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        rxa = addr;
        tick();
        tick();
        check(tag, {8'h00, rxd}, {8'h00, exp});
    endtask

    task automatic fd_pulse(input logic [15:0] exp_pkt);
        fd_eth = 1'b1;
        tick();
        check("fs_release", {15'd0, fs_eth}, 16'd0);
        fd_eth = 1'b0;
        tick();
        check("pkt_cnt", pkt_cnt, exp_pkt);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rx_idle();
        fd_eth = 1'b0;
        #1;
        check("rst_fs", {15'd0, fs_eth}, 16'd0);
        check("rst_rxd", {8'h00, rxd}, 16'd0);
        check("rst_pkt", pkt_cnt, 16'd0);
        check("rst_drop", drop_cnt, 16'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state, then one IDLE cycle before LOAD
        #2;
        do_reset();
        tick();

        // Valid packet and its pipelined readback
        fill(8'h10);
        send_bytes(0, 18, 1'b0);
        check("fs_rise", {15'd0, fs_eth}, 16'd1);
        keep_gold();
        read_all("rd_pkt1");

        // Frame during SEND is discarded and leaves the buffer alone
        fill(8'h40);
        send_bytes(0, 18, 1'b0);
        check("send_drop", drop_cnt, 16'd1);
        check("send_fs", {15'd0, fs_eth}, 16'd1);
        read_all("rd_keep");
        fd_pulse(16'd1);

        // Rejected frames: bad header, short, long, MAC error
        fill(8'h20); frm[1] = 8'hAB;
        send_bytes(0, 18, 1'b0); tick();
        check("drop_head", drop_cnt, 16'd2);
        fill(8'h30);
        send_bytes(0, 17, 1'b0); tick();
        check("drop_short", drop_cnt, 16'd3);
        fill(8'h50);
        send_bytes(0, 19, 1'b0); tick();
        check("drop_long", drop_cnt, 16'd4);
        fill(8'h60);
        send_bytes(0, 18, 1'b1); tick();
        check("drop_err", drop_cnt, 16'd5);
        check("rej_fs", {15'd0, fs_eth}, 16'd0);
        check("rej_pkt", pkt_cnt, 16'd1);
        read1("rej_written", BASE + 8'd17, 8'h60 + 8'd17);

        // Frame starting in HOLD, fd_eth falls mid-frame
        fill(8'h70);
        send_bytes(0, 18, 1'b0);
        keep_gold();
        fd_eth = 1'b1;
        tick();
        fill(8'h80);
        for (int i = 0; i < 18; i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = (i == 17);
            if (i == 3) fd_eth = 1'b0;
            tick();
        end
        rx_idle();
        check("hold_pkt", pkt_cnt, 16'd2);
        check("hold_skip", drop_cnt, 16'd6);
        read_all("rd_skip");
        fill(8'h90);
        send_bytes(0, 18, 1'b0);
        check("after_skip_fs", {15'd0, fs_eth}, 16'd1);
        keep_gold();
        read_all("rd_pkt5");
        fd_pulse(16'd3);

        // Same-address write and read on one edge returns the old byte
        fill(8'hA0);
        for (int i = 0; i < 18; i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = (i == 17);
            rxa      = BASE + 8'(i);
            tick();
            if (i >= 1) check("rw_old", {8'h00, rxd}, {8'h00, gold[i-1]});
        end
        rx_idle();
        check("rw_fs", {15'd0, fs_eth}, 16'd1);
        keep_gold();
        read1("rw_new", BASE + 8'd5, 8'h1E);
        fd_pulse(16'd4);

        // Reset in the middle of a frame; the tail is skipped once out of IDLE
        fill(8'hB0);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = 1'b0;
            tick();
        end
        do_reset();
        send_bytes(5, 18, 1'b0);
        check("midrst_drop", drop_cnt, 16'd1);
        check("midrst_fs", {15'd0, fs_eth}, 16'd0);
        fill(8'hC0);
        send_bytes(0, 18, 1'b0);
        check("midrst_ok", {15'd0, fs_eth}, 16'd1);

        // Reset during SEND, then a clean packet
        do_reset();
        tick();
        fill(8'hD0);
        send_bytes(0, 18, 1'b0);
        check("sendrst_ok", {15'd0, fs_eth}, 16'd1);
        keep_gold();
        read_all("rd_pkt7");
        fd_pulse(16'd1);

        // drop_cnt wrap: a one-byte bad frame every cycle adds one per cycle
        do_reset();
        tick();
        for (int i = 0; i < 65536; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h00;
            rx_last  = 1'b1;
            tick();
            if (i == 3) check("drop_dual", drop_cnt, 16'd4);
        end
        rx_idle();
        check("drop_wrap", drop_cnt, 16'd0);
        check("wrap_pkt", pkt_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/com_recv.md
# com_recv

Receive stage directly upstream of the command parser. Takes the UDP payload byte stream from the Ethernet receive path and writes one command packet into a local 256x8 buffer starting at `RAM_ADDR_INIT`. It checks the header and length, then hands the packet to the parser over the `fs_eth`/`fd_eth` handshake. The parser reads the buffer through a registered read port with a fixed 2-cycle latency.

## Interface
- `RAM_ADDR_INIT`, 8'h0A: buffer address of packet byte 0.
- `PKT_LEN`, 8'h12: required packet length in bytes (18).
- `STD_HEAD`, 16'h55AA: required header; byte 0 = 8'h55, byte 1 = 8'hAA.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `rx_valid`  input  1  `rx_data` valid this cycle; no backpressure.
- `rx_data`  input  8  payload byte.
- `rx_last`  input  1  final byte of frame; qualified by `rx_valid`.
- `rx_err`  input  1  frame error (CRC or length from MAC); sampled with `rx_valid & rx_last`.
- `fs_eth`  output  1  packet ready in buffer.
- `fd_eth`  input  1  parser has consumed the packet.
- `rxa`  input  8  read address.
- `rxd`  output  8  read data; returns the byte at the `rxa` value from 2 cycles earlier.
- `pkt_cnt`  output  16  accepted packets; wraps at 16'hFFFF.
- `drop_cnt`  output  16  rejected or discarded frames; wraps at 16'hFFFF.

## Operation
- **States** (one-hot): IDLE, LOAD, DROP, SEND, HOLD.
- **IDLE**: one cycle after reset, then go to LOAD.
- **LOAD**: each `rx_valid` byte is handled by byte index `idx`.
  - If `idx < PKT_LEN`, the byte is written to `RAM_ADDR_INIT + idx`.
  - `idx` saturates at 8'hFF. Bytes at `idx >= PKT_LEN` are not written.
  - `hok` flag: set on `idx==0` when the byte is 8'h55. Cleared on `idx==1` when the byte is not 8'hAA.
- **End of frame in LOAD**: on `rx_valid & rx_last`, accept if `idx==PKT_LEN-1`, `hok` (including the current byte) and `!rx_err`.
  - Accept: go to SEND.
  - Otherwise: go to DROP.
  - `idx` and `hok` are cleared either way.
- **DROP**: one cycle, `drop_cnt+1`, then back to LOAD.
- **SEND**: `fs_eth=1`. Buffer writes are blocked. Go to HOLD when `fd_eth=1`.
- **HOLD**: `fs_eth=0`. Go to LOAD when `fd_eth=0`; `pkt_cnt+1` on that transition.
- **Frames arriving in SEND/HOLD**: fully discarded, no writes. `drop_cnt+1` on their `rx_valid & rx_last`.
- **Mid-frame entry to LOAD**: `in_frame` tracks frame activity independent of state. It is set on `rx_valid & !rx_last` and cleared on `rx_valid & rx_last`. If LOAD is entered with `in_frame=1`, `skip` is set.
  - While `skip=1`, bytes are discarded.
  - At that frame's `rx_last`, `skip` clears and `drop_cnt+1`; the state stays LOAD.
- **Same-cycle counter events**: a DROP increment and a discard increment in the same cycle add 2.
- **Read port**: address is registered into the RAM, and the RAM output is registered to `rxd`.
  - Read-first: a read and write to the same address in the same cycle returns the old byte.
- **Buffer contents**: not cleared by reset. Contents at unwritten addresses are undefined.
- **Reset values**: `fs_eth=0`, `rxd=8'h00`, `pkt_cnt=0`, `drop_cnt=0`, state IDLE, `idx=0`, `hok=0`, `in_frame=0`, `skip=0`.
- **Reset mid-frame**: the rest of that frame is discarded via `in_frame`/`skip` once out of IDLE. `in_frame` is 0 after reset, so bytes already in flight before the reset are treated as the start of a frame.

## Timing
- **Write to hand-off**: last byte sampled at edge T; `fs_eth=1` from T+1. The byte is readable from T+1, since `rxa` applied at T+1 gives `rxd` at T+3.
- **Read latency**: exactly 2 cycles, fully pipelined, one read per cycle.
- **`fs_eth` release**: held until the first cycle `fd_eth=1` is sampled; drops 1 cycle after.
- **Next packet**: LOAD is re-entered 1 cycle after `fd_eth` is sampled low. The earliest next packet byte is accepted in that cycle.
- **Buffer stability**: the buffer is stable from `fs_eth` rise until the HOLD→LOAD transition.

## Structure
- **Package `com_pkg`**: `STD_HEAD`, `PKT_LEN`, `RAM_ADDR_INIT`, `DATA_LATENCY`=2 and the state encodings. These are shared with the parser.
- **Sub-module `com_ram`**: 256x8 simple dual-port RAM, one write port and a registered read port. `com_recv` adds the output register.

## Test plan
- Valid 18-byte frame 55 AA 00 01 00 1E … → `fs_eth` rises the cycle after `rx_last`. Reading `rxa`=8'h0A..8'h1B returns the bytes at 2-cycle latency. `fd_eth` pulse → `pkt_cnt=1`.
- Header 55 AB, or length 17, or length 19, or `rx_err=1` → no `fs_eth`, `drop_cnt` increments once each, and buffer bytes at `idx >= 18` remain unchanged.
- Second frame sent while `fs_eth=1` → buffer unchanged (readback equals the first packet), `drop_cnt+1`, `pkt_cnt` unaffected.
- Frame starting in HOLD, with `fd_eth` falling mid-frame → the remaining bytes are skipped, `drop_cnt+1`, and the next clean frame is accepted.
- `rst` low mid-frame and again during SEND → all outputs return to their reset values, and the next full valid frame is accepted.
- Read/write to the same address in the same cycle → `rxd` returns the old byte. 65536 drops → `drop_cnt` wraps to 0.
